// File: rtl/multi_reaction_timer.sv
// Multi-player reaction timer: start-light sequence, random hold, per-player
// reaction capture with false-start detection, winner and best-time tracking.
module multi_reaction_timer #(
    parameter int NUM_LIGHTS   = 10,
    parameter int NUM_PLAYERS  = 2,
    parameter int TIME_W       = 14,
    parameter int STEP_MS      = 500,
    parameter int MIN_DELAY_MS = 200,
    parameter int TIMEOUT_MS   = 9999,
    localparam int WIN_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_ms,
    input  logic                          start,
    input  logic [NUM_PLAYERS-1:0]        button,
    output logic [NUM_LIGHTS-1:0]         lights,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PLAYERS*TIME_W-1:0] result,
    output logic [NUM_PLAYERS-1:0]        valid,
    output logic [NUM_PLAYERS-1:0]        false_start,
    output logic [WIN_W-1:0]              winner,
    output logic                          winner_valid,
    output logic [TIME_W-1:0]             best_time
);

    localparam int HOLD_MAX = MIN_DELAY_MS + 2047;
    localparam int PH_MAX   = (STEP_MS > HOLD_MAX) ? STEP_MS : HOLD_MAX;
    localparam int PH_W     = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTS,
        S_HOLD,
        S_GO,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic                   start_q;
    logic [NUM_PLAYERS-1:0] button_q;
    logic [12:0]            lfsr;
    logic [PH_W-1:0]        phase_cnt;
    logic [PH_W-1:0]        hold_len;
    logic [TIME_W-1:0]      ms_cnt;
    logic                   eval_pending;

    logic                   start_rise;
    logic [NUM_PLAYERS-1:0] press;
    logic [NUM_PLAYERS-1:0] fs_early;
    logic [NUM_PLAYERS-1:0] go_hits;
    logic [NUM_PLAYERS-1:0] valid_go;
    logic [NUM_LIGHTS-1:0]  lights_step;
    logic                   lights_last;
    logic                   step_due;
    logic                   hold_due;
    logic                   timeout;
    logic                   all_fs;
    logic                   all_resolved;

    logic                   win_any;
    logic [WIN_W-1:0]       win_idx;
    logic [TIME_W-1:0]      win_res;

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    // Edge detection and phase events shared by the FSM and the datapath.
    always_comb begin
        start_rise   = start & ~start_q;
        press        = button & ~button_q;
        lights_step  = (lights << 1) | NUM_LIGHTS'(1);
        lights_last  = &lights_step;
        step_due     = tick_ms && (phase_cnt == PH_W'(STEP_MS - 1));
        hold_due     = tick_ms && (phase_cnt == hold_len - PH_W'(1));
        fs_early     = false_start | press;
        all_fs       = &fs_early;
        go_hits      = press & ~false_start & ~valid;
        valid_go     = valid | go_hits;
        all_resolved = &(valid_go | false_start);
        timeout      = tick_ms && (ms_cnt == TIME_W'(TIMEOUT_MS - 1));
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start_rise) state_next = S_LIGHTS;
            S_LIGHTS: begin
                if (all_fs)                       state_next = S_DONE;
                else if (step_due && lights_last) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (all_fs)        state_next = S_DONE;
                else if (hold_due) state_next = S_GO;
            end
            S_GO: if (all_resolved || timeout) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Lowest valid result; strict less-than keeps ties on the lower index.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_res = '1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (valid[p] && (!win_any || result[p*TIME_W +: TIME_W] < win_res)) begin
                win_any = 1'b1;
                win_idx = WIN_W'(p);
                win_res = result[p*TIME_W +: TIME_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q      <= 1'b0;
            button_q     <= '0;
            lfsr         <= 13'h1;
            phase_cnt    <= '0;
            hold_len     <= '0;
            ms_cnt       <= '0;
            eval_pending <= 1'b0;
            lights       <= '0;
            result       <= '0;
            valid        <= '0;
            false_start  <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            best_time    <= '1;
        end else begin
            start_q      <= start;
            button_q     <= button;
            lfsr         <= {lfsr[11:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};
            eval_pending <= (state != S_DONE) && (state_next == S_DONE);

            // Scoring runs first so a start edge in the same cycle still clears winner_valid.
            if (state == S_DONE && eval_pending) begin
                winner       <= win_idx;
                winner_valid <= win_any;
                if (win_any && win_res < best_time) best_time <= win_res;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_rise) begin
                        lights       <= '0;
                        phase_cnt    <= '0;
                        result       <= '0;
                        valid        <= '0;
                        false_start  <= '0;
                        winner_valid <= 1'b0;
                    end
                end
                S_LIGHTS: begin
                    false_start <= fs_early;
                    if (step_due) begin
                        phase_cnt <= '0;
                        lights    <= lights_step;
                        if (lights_last) hold_len <= PH_W'(MIN_DELAY_MS) + PH_W'(lfsr[10:0]);
                    end else if (tick_ms) begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                S_HOLD: begin
                    false_start <= fs_early;
                    if (hold_due) begin
                        phase_cnt <= '0;
                        lights    <= '0;
                        ms_cnt    <= '0;
                    end else if (tick_ms) begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                S_GO: begin
                    valid <= valid_go;
                    if (tick_ms) ms_cnt <= ms_cnt + TIME_W'(1);
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (go_hits[p])
                            result[p*TIME_W +: TIME_W] <= ms_cnt;
                        else if (timeout && !valid[p] && !false_start[p])
                            result[p*TIME_W +: TIME_W] <= TIME_W'(TIMEOUT_MS);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Randomized self-checking bench for multi_reaction_timer: each round is planned
// as press times, and a round-level model predicts results, winner and best time.
module tb_multi_reaction_timer;

    localparam int NL    = 10;
    localparam int NP    = 2;
    localparam int TW    = 14;
    localparam int STEP  = 500;
    localparam int MIN_D = 200;
    localparam int TMO   = 9999;
    localparam int WW    = 1;
    localparam int HOLD_MAX = MIN_D + 2047;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick_ms;
    logic            start;
    logic [NP-1:0]   button;
    logic [NL-1:0]   lights;
    logic            busy;
    logic            done;
    logic [NP*TW-1:0] result;
    logic [NP-1:0]   valid;
    logic [NP-1:0]   false_start;
    logic [WW-1:0]   winner;
    logic            winner_valid;
    logic [TW-1:0]   best_time;

    multi_reaction_timer #(
        .NUM_LIGHTS(NL), .NUM_PLAYERS(NP), .TIME_W(TW),
        .STEP_MS(STEP), .MIN_DELAY_MS(MIN_D), .TIMEOUT_MS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .start(start), .button(button),
        .lights(lights), .busy(busy), .done(done), .result(result), .valid(valid),
        .false_start(false_start), .winner(winner), .winner_valid(winner_valid),
        .best_time(best_time)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int ticks      = 0;
    bit gap        = 1'b0;

    // Round plan: -1 means "never".
    int plan_fs [NP];   // tick offset from round start for an early press
    int plan_go [NP];   // GO count at which the player presses
    bit plan_hold [NP]; // button held from before start until GO count 5
    int plan_start_go;  // GO count at which a stray start pulse is sent
    bit plan_gap;       // irregular tick_ms during GO

    logic [TW-1:0] exp_res [NP];
    logic [NP-1:0] exp_val, exp_fs;
    logic          exp_wv;
    logic [WW-1:0] exp_win;
    logic [TW-1:0] model_best;
    bit            exp_all_fs, exp_timeout;

    task automatic cycle();
        tick_ms = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (tick_ms) ticks++;
    endtask

    task automatic clear_plan();
        for (int p = 0; p < NP; p++) begin
            plan_fs[p]   = -1;
            plan_go[p]   = -1;
            plan_hold[p] = 1'b0;
        end
        plan_start_go = -1;
        plan_gap      = 1'b0;
    endtask

    // Round outcome from the rules: early pressers score nothing, the rest score
    // their press count or the timeout; winner is the smallest score, first index.
    task automatic model_expect();
        int min_v;
        exp_all_fs  = 1'b1;
        exp_timeout = 1'b0;
        for (int p = 0; p < NP; p++) begin
            exp_fs[p] = (plan_fs[p] >= 0);
            if (!exp_fs[p]) exp_all_fs = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            if (exp_fs[p]) begin
                exp_res[p] = '0;
                exp_val[p] = 1'b0;
            end else if (plan_go[p] >= 0 && plan_go[p] < TMO) begin
                exp_res[p] = TW'(plan_go[p]);
                exp_val[p] = 1'b1;
            end else begin
                exp_res[p]  = TW'(TMO);
                exp_val[p]  = 1'b0;
                exp_timeout = 1'b1;
            end
        end
        min_v = 1 << TW;
        for (int p = 0; p < NP; p++)
            if (exp_val[p] && int'(exp_res[p]) < min_v) min_v = int'(exp_res[p]);
        exp_wv  = (exp_val != '0);
        exp_win = '0;
        for (int p = NP - 1; p >= 0; p--)
            if (exp_val[p] && int'(exp_res[p]) == min_v) exp_win = WW'(p);
        if (exp_wv && TW'(min_v) < model_best) model_best = TW'(min_v);
    endtask

    task automatic run_round(input string tag);
        int base, h0, g0, hold, iter, last_press_iter, budget, off;
        bit fs_issued [NP];
        bit go_issued [NP];
        bit start_issued, lights_ok;
        logic [NL-1:0] m;
        logic [NP-1:0] btn;

        model_expect();
        for (int p = 0; p < NP; p++) begin
            fs_issued[p] = 1'b0;
            go_issued[p] = 1'b0;
            btn[p]       = plan_hold[p];
        end
        button = btn;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        base  = ticks;

        compared++;
        if (busy !== 1'b1 || done !== 1'b0 || lights !== '0 || valid !== '0 ||
            false_start !== '0 || winner_valid !== 1'b0 || result !== '0) begin
            mismatched++;
            $display("FAIL %s start_clear: busy=%b done=%b lights=%h valid=%b fs=%b wv=%b result=%h, want busy=1 rest 0",
                     tag, busy, done, lights, valid, false_start, winner_valid, result);
        end

        // LIGHTS and HOLD: watch the fill pattern and issue any early presses.
        h0 = -1; lights_ok = 1'b1; iter = 0; last_press_iter = -1;
        budget = NL * STEP + HOLD_MAX + 50;
        forever begin
            if (done === 1'b1) break;
            if (h0 < 0 && lights === '1) h0 = ticks;
            if (h0 >= 0 && lights === '0) break;
            off = ticks - base;
            if (h0 < 0) begin
                m = '0;
                for (int i = 0; i < NL; i++) if (i < off / STEP) m[i] = 1'b1;
                if (lights !== m) lights_ok = 1'b0;
            end else if (lights !== '1) begin
                lights_ok = 1'b0;
            end
            btn = '0;
            for (int p = 0; p < NP; p++) begin
                if (plan_hold[p]) btn[p] = 1'b1;
                if (!fs_issued[p] && plan_fs[p] >= 0 && plan_fs[p] == off) begin
                    btn[p] = 1'b1;
                    fs_issued[p] = 1'b1;
                    last_press_iter = iter;
                end
            end
            button = btn;
            cycle();
            iter++;
            if (iter >= budget) begin
                compared++; mismatched++;
                $display("FAIL %s phase_budget: lights=%b done=%b, want GO or DONE within %0d cycles",
                         tag, lights, done, budget);
                button = '0;
                return;
            end
        end

        compared++;
        if (!lights_ok) begin
            mismatched++;
            $display("FAIL %s lights_sequence: lights=%b diverged from one bit per %0d ticks", tag, lights, STEP);
        end

        if (exp_all_fs) begin
            compared++;
            if (done !== 1'b1 || iter != last_press_iter + 1) begin
                mismatched++;
                $display("FAIL %s all_fs_done: done=%b at cycle %0d, want done=1 at cycle %0d",
                         tag, done, iter, last_press_iter + 1);
            end
        end else begin
            compared++;
            if (h0 < 0 || h0 - base != NL * STEP || done === 1'b1) begin
                mismatched++;
                $display("FAIL %s lights_full: full at tick %0d done=%b, want tick %0d done=0",
                         tag, h0 - base, done, NL * STEP);
            end
            if (done !== 1'b1) begin
                hold = ticks - h0;
                compared++;
                if (hold < MIN_D || hold > HOLD_MAX) begin
                    mismatched++;
                    $display("FAIL %s hold_len: got %0d ticks, want %0d..%0d", tag, hold, MIN_D, HOLD_MAX);
                end

                // GO: press at the planned counts, counting ticks seen since GO entry.
                g0 = ticks; gap = plan_gap; iter = 0; last_press_iter = -1; start_issued = 1'b0;
                while (done !== 1'b1) begin
                    off = ticks - g0;
                    btn = '0;
                    start = 1'b0;
                    for (int p = 0; p < NP; p++) begin
                        if (plan_hold[p] && off < 5) btn[p] = 1'b1;
                        if (!go_issued[p] && plan_go[p] >= 0 && plan_go[p] == off) begin
                            btn[p] = 1'b1;
                            go_issued[p] = 1'b1;
                            if (!exp_fs[p]) last_press_iter = iter;
                        end
                    end
                    if (plan_start_go >= 0 && !start_issued && off == plan_start_go) begin
                        start = 1'b1;
                        start_issued = 1'b1;
                    end
                    button = btn;
                    cycle();
                    iter++;
                    if (iter > 2 * TMO + 50) begin
                        compared++; mismatched++;
                        $display("FAIL %s go_budget: done=%b after %0d cycles of GO", tag, done, iter);
                        gap = 1'b0; start = 1'b0; button = '0;
                        return;
                    end
                end
                start = 1'b0;
                gap   = 1'b0;
                compared++;
                if (exp_timeout) begin
                    if (ticks - g0 != TMO) begin
                        mismatched++;
                        $display("FAIL %s timeout_ticks: DONE after %0d GO ticks, want %0d", tag, ticks - g0, TMO);
                    end
                end else if (iter != last_press_iter + 1) begin
                    mismatched++;
                    $display("FAIL %s done_after_press: DONE at cycle %0d, want cycle %0d",
                             tag, iter, last_press_iter + 1);
                end
            end
        end

        // One more cycle so the DONE-entry scoring is visible.
        button = '0;
        cycle();
        compared++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s done_state: done=%b busy=%b, want done=1 busy=0", tag, done, busy);
        end
        for (int p = 0; p < NP; p++) begin
            compared++;
            if (result[p*TW +: TW] !== exp_res[p]) begin
                mismatched++;
                $display("FAIL %s result%0d: got %0d, want %0d", tag, p, result[p*TW +: TW], exp_res[p]);
            end
        end
        compared++;
        if (valid !== exp_val) begin
            mismatched++;
            $display("FAIL %s valid: got %b, want %b", tag, valid, exp_val);
        end
        compared++;
        if (false_start !== exp_fs) begin
            mismatched++;
            $display("FAIL %s false_start: got %b, want %b", tag, false_start, exp_fs);
        end
        compared++;
        if (winner_valid !== exp_wv) begin
            mismatched++;
            $display("FAIL %s winner_valid: got %b, want %b", tag, winner_valid, exp_wv);
        end
        if (exp_wv) begin
            compared++;
            if (winner !== exp_win) begin
                mismatched++;
                $display("FAIL %s winner: got %0d, want %0d", tag, winner, exp_win);
            end
        end
        compared++;
        if (best_time !== model_best) begin
            mismatched++;
            $display("FAIL %s best_time: got %0d, want %0d", tag, best_time, model_best);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; button = '0; tick_ms = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({lights, result, valid, false_start, winner, winner_valid, busy, done} !== '0 || best_time !== '1) begin
            mismatched++;
            $display("FAIL reset_values: lights=%h result=%h valid=%b fs=%b win=%b wv=%b busy=%b done=%b best=%h, want zeros and best all-ones",
                     lights, result, valid, false_start, winner, winner_valid, busy, done, best_time);
        end
        rst = 1'b0;
        model_best = '1;
        repeat (3) cycle();
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_hold: busy=%b done=%b without start, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        clear_plan();
        plan_go[0] = 237;
        plan_go[1] = 412;
        run_round("basic");
    endtask

    task automatic test_false_start();
        clear_plan();
        plan_fs[1] = $urandom_range(1, NL * STEP - 1);
        plan_go[1] = $urandom_range(10, 250);
        plan_go[0] = 300;
        run_round("false_start");
    endtask

    task automatic test_timeout();
        clear_plan();
        run_round("timeout");
    endtask

    task automatic test_same_cycle();
        clear_plan();
        plan_go[0] = 150;
        plan_go[1] = 150;
        run_round("same_cycle");
        clear_plan();
        plan_go[0] = $urandom_range(181, 400);
        plan_go[1] = 180;
        plan_gap   = 1'b1;
        run_round("best_kept");
    endtask

    task automatic test_reset_hold();
        int budget;
        clear_plan();
        start = 1'b1;
        cycle();
        start = 1'b0;
        budget = 0;
        while (lights !== '1 && budget < NL * STEP + 20) begin
            cycle();
            budget++;
        end
        repeat ($urandom_range(1, 100)) cycle();
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({lights, result, valid, false_start, winner, winner_valid, busy, done} !== '0 || best_time !== '1) begin
            mismatched++;
            $display("FAIL reset_in_hold: lights=%h busy=%b done=%b valid=%b fs=%b wv=%b best=%h, want reset values",
                     lights, busy, done, valid, false_start, winner_valid, best_time);
        end
        @(negedge clk);
        rst = 1'b0;
        model_best = '1;
        plan_go[0] = $urandom_range(1, 600);
        plan_go[1] = $urandom_range(1, 600);
        plan_gap   = 1'b1;
        run_round("after_reset");
    endtask

    task automatic test_double_false_start();
        clear_plan();
        plan_fs[0] = $urandom_range(1, 1000);
        plan_fs[1] = $urandom_range(1, 1000);
        run_round("double_fs");
        clear_plan();
        plan_hold[0]  = 1'b1;
        plan_go[0]    = $urandom_range(60, 500);
        plan_go[1]    = $urandom_range(60, 500);
        plan_start_go = 50;
        run_round("start_in_go");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_timeout();
        test_same_cycle();
        test_reset_hold();
        test_double_false_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
